// File: rtl/output_serializer.sv
// Packet FIFO feeding a byte serializer: whole packets are queued, then emitted one
// byte per accepted transfer with sop/eop framing and back-to-back packet chaining.
module output_serializer #(
  parameter int BYTE_W    = 8,
  parameter int PKT_BYTES = 4,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          pkt_avail,
  input  logic [PKT_BYTES*BYTE_W-1:0]   pkt,
  input  logic                          flush,
  input  logic                          read_from_ob,
  output logic [BYTE_W-1:0]             payload_outbound,
  output logic                          put_outbound,
  output logic                          sop,
  output logic                          eop,
  output logic                          full,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          overflow
);

  localparam int PKT_W = PKT_BYTES * BYTE_W;
  localparam int IDX_W = $clog2(PKT_BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_full;
  logic [PKT_W-1:0]   r_buf;
  logic [PKT_W-1:0]   r_mem [DEPTH];

  logic               w_push;
  logic               w_pop;
  logic               w_last;
  logic [IDX_W-1:0]   w_sel;
  logic [CNT_W-1:0]   w_count_nxt;

  assign w_last       = (r_idx == LAST_IDX);
  assign put_outbound = (r_state == S_SEND) && read_from_ob && !flush;
  assign w_push       = pkt_avail && !r_full && !flush;
  // The head packet is loaded either from idle or on the last byte of the current one.
  assign w_pop        = !flush && (r_count != '0) &&
                        ((r_state == S_IDLE) || (put_outbound && w_last));

  assign sop      = put_outbound && (r_idx == '0);
  assign eop      = put_outbound && w_last;
  assign full     = r_full;
  assign count    = r_count;
  assign overflow = pkt_avail && r_full && !flush;

  assign w_sel = (MSB_FIRST != 0) ? (LAST_IDX - r_idx) : r_idx;

  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    payload_outbound = '0;
    if (r_state == S_SEND) begin
      for (int i = 0; i < PKT_BYTES; i++) begin
        if (w_sel == IDX_W'(i)) payload_outbound = r_buf[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_W'(1);
  end

  // NOTE: packet storage has no reset; count gates every read, so stale entries are never
  // observed, and a reset-free array can map onto RAM.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= pkt;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_buf    <= '0;
    end else if (flush) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_buf    <= r_mem[r_rd_ptr];
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_SEND;
            r_idx   <= '0;
          end
        end
        S_SEND: begin
          if (put_outbound) begin
            if (!w_last) begin
              r_idx <= r_idx + IDX_W'(1);
            end else begin
              r_idx <= '0;
              if (!w_pop) r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 Parameter BYTE_W, default 8, sets the bits per serialized byte.
REQ-002 Parameter PKT_BYTES, default 4, sets the bytes per packet; it SHALL be at least 2.
REQ-003 Parameter DEPTH, default 4, sets the packet FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-004 Parameter MSB_FIRST, default 1; 1 sends the highest-indexed byte first, 0 sends byte 0 first.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 pkt_avail  input  1  write strobe for pkt.
REQ-008 pkt  input  PKT_BYTES*BYTE_W  packet to enqueue.
REQ-009 flush  input  1  synchronous abort of the FIFO and the current packet.
REQ-010 read_from_ob  input  1  downstream ready, sampled every cycle.
REQ-011 payload_outbound  output  BYTE_W  current byte.
REQ-012 put_outbound  output  1  byte transfer strobe.
REQ-013 sop / eop  output  1 each  first and last byte of a packet, qualified by put_outbound.
REQ-014 full  output  1  FIFO holds DEPTH packets.
REQ-015 count  output  $clog2(DEPTH+1)  FIFO occupancy.
REQ-016 overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-017 FIFO write: accepted on an edge where pkt_avail=1, full=0 and flush=0.
REQ-018 Dropped write: pkt_avail=1 with full=1 SHALL be discarded and SHALL assert overflow in that cycle; a write in a flush cycle is discarded silently.
REQ-019 count and full are registered; full=1 exactly when count==DEPTH.
REQ-020 Push and pop on the same edge leave count unchanged; pointers wrap modulo DEPTH.
REQ-021 States: IDLE and SEND; byte index idx runs from 0 to PKT_BYTES-1.
REQ-022 IDLE: when count>0, pop the head into the byte buffer, set idx=0 and go to SEND; this does not depend on read_from_ob.
REQ-023 put_outbound = (state==SEND) && read_from_ob, combinational.
REQ-024 Stall: no put while read_from_ob=0; payload_outbound and idx hold.
REQ-025 payload_outbound selects buffer byte PKT_BYTES-1-idx when MSB_FIRST=1, otherwise byte idx; it SHALL be 0 in IDLE.
REQ-026 sop = put_outbound && idx==0; eop = put_outbound && idx==PKT_BYTES-1.
REQ-027 idx increments on each put that is not the last byte.
REQ-028 Last-byte put with count>0: pop and load the next packet on the same edge, set idx=0 and stay in SEND, with no idle cycle between packets.
REQ-029 Last-byte put with count==0: return to IDLE.
REQ-030 Latency: a pkt_avail into an empty, idle block gives the first put 2 cycles later when read_from_ob=1.
REQ-031 flush=1: on the next edge, count=0, state=IDLE and idx=0; no put_outbound occurs in the flush cycle.
REQ-032 Bytes of an aborted packet SHALL never be emitted.

Reset
REQ-033 While reset_n=0: state=IDLE; idx, count, pointers and buffer = 0; all outputs = 0.
REQ-034 Reset mid-packet discards the FIFO contents and the partial packet; the first packet written after release starts with sop.

Verification
REQ-035 Single packet, defaults, read_from_ob=1, pkt=0xAABBCCDD written at cycle 0 -> puts in cycles 2-5 carrying AA, BB, CC, DD; sop with AA, eop with DD.
REQ-036 Stall: read_from_ob=0 for 3 cycles after AA -> BB held, no put for 3 cycles, then BB, CC, DD with eop on DD.
REQ-037 Back-to-back packets 0x01020304 and 0x05060708 -> 8 consecutive puts, no gap; eop on 04, sop on 05.
REQ-038 Overflow: read_from_ob=0, 6 consecutive writes -> first packet in the buffer, count=4, full=1, 6th write dropped with overflow pulse; after release exactly 5 packets are emitted, in order.
REQ-039 Flush after 2 bytes of a packet with 2 queued -> no further put, count=0; the next written packet emits with sop on its first byte.
REQ-040 MSB_FIRST=0 with pkt=0xAABBCCDD -> DD, CC, BB, AA; reset_n pulsed mid-packet -> all outputs 0, no residual bytes.
